uart_axi_loader: RTL and testbench

UART-driven AXI4 initiator that lets a host PC load and inspect system memory over the serial link, then start the core. It sits beside the core as a second AXI master on the crossbar in front of `axi_mm_ram`, driving single-beat reads and writes from byte-level UART commands. It also gates the core's fetch enable.

---
 rtl/uart_axi_loader_if.sv | 92 +++++++++
 rtl/uart_axi_loader.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_uart_axi_loader.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_axi_loader_if.sv
// AXI_BUS: AXI4 bus bundle shared by the UART loader (master side) and the
// crossbar/RAM or a bench slave model (slave side).
//   Parameters: AXI_ADDR_WIDTH, AXI_DATA_WIDTH, AXI_ID_WIDTH, AXI_USER_WIDTH
//   Channels  : AW, W, B, AR, R with the usual valid/ready handshakes
//   Modports  : Master (drives requests, accepts responses), Slave (mirror)
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 2,
  parameter int unsigned AXI_USER_WIDTH = 2
);
  localparam int unsigned STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_region;
  logic [3:0]                aw_qos;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0]     w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_region;
  logic [3:0]                ar_qos;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_region, aw_qos, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache,
           ar_prot, ar_region, ar_qos, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/uart_axi_loader.sv
// uart_axi_loader: UART-driven single-beat AXI4 initiator. A host sends
// W (0x57 addr[4] data[4]), R (0x52 addr[4]) or G (0x47) commands over 8N1
// serial; the block issues the AXI access and replies over TX.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   rx_i / tx_o      : UART lines, idle high
//   axi              : AXI_BUS.Master, single-beat INCR, IDs/user tied to 0
//   fetch_enable_o   : sticky core fetch enable, set by G
//   busy_o           : high whenever the command FSM is not IDLE
// Optional feature macro UART_AXI_LOADER_TIMEOUT_EN: abandons a partial
// ADDR/DATA frame after TIMEOUT_CYCLES without a new byte.
module uart_axi_loader #(
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ID_WIDTH   = 2,
  parameter int unsigned AXI_USER_WIDTH = 2,
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned BAUD_RATE      = 115_200,
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  rx_i,
  output logic  tx_o,
  AXI_BUS.Master axi,
  output logic  fetch_enable_o,
  output logic  busy_o
);
  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = $clog2(DIV + 1);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(DIV / 2);

  // ---------------- UART receiver ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e        rx_state_q;
  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q, rx_byte_q;
  logic             rx_valid_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      rx_valid_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= '0;
          end
        end
        RX_START: begin
          // A glitch shorter than half a bit is not a start bit.
          if (rx_cnt_q == HALF_BIT) begin
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_state_q <= rx_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_bit_q   <= rx_bit_q + 1'b1;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
        default: begin
          if (rx_cnt_q == BIT_END) begin
            rx_cnt_q   <= '0;
            rx_state_q <= RX_IDLE;
            // Stop bit low: framing error, byte silently dropped.
            if (rx_sync_q) begin
              rx_valid_q <= 1'b1;
              rx_byte_q  <= rx_shift_q;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // ---------------- Command FSM + transmitter ----------------
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_AXI_REQ, S_AXI_RESP, S_REPLY} state_e;
  state_e                    state_q;
  logic [1:0]                byte_cnt_q;
  logic                      is_write_q;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] data_q;
  logic                      aw_valid_q, w_valid_q, b_ready_q, ar_valid_q, r_ready_q;
  logic                      fetch_en_q, busy_q, tx_q;
  logic [8:0]                tx_shift_q;
  logic [CNT_W-1:0]          tx_cnt_q;
  logic [3:0]                tx_bit_q;
  logic [31:0]               reply_q;
  logic [2:0]                reply_left_q;
`ifdef UART_AXI_LOADER_TIMEOUT_EN
  logic [31:0]               to_cnt_q;
`endif

  // Reply launch request: a reply starts on the same edge the triggering
  // event is seen so the start bit appears one cycle later.
  logic        reply_en_d;
  logic [39:0] reply_data_d;
  logic [2:0]  reply_len_d;

  always_comb begin
    reply_en_d   = 1'b0;
    reply_data_d = '0;
    reply_len_d  = 3'd1;
    case (state_q)
      S_IDLE: begin
        if (rx_valid_q && rx_byte_q != 8'h57 && rx_byte_q != 8'h52) begin
          reply_en_d   = 1'b1;
          reply_data_d = {32'h0, (rx_byte_q == 8'h47) ? 8'h06 : 8'h3F};
        end
      end
      S_AXI_RESP: begin
        if (is_write_q && axi.b_valid && b_ready_q) begin
          reply_en_d   = 1'b1;
          reply_data_d = {32'h0, axi.b_resp[1] ? 8'h15 : 8'h06};
        end else if (!is_write_q && axi.r_valid && r_ready_q) begin
          reply_en_d = 1'b1;
          if (axi.r_resp[1]) begin
            reply_data_d = {32'h0, 8'h15};
          end else begin
            reply_data_d = {axi.r_data, 8'h06};
            reply_len_d  = 3'd5;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      byte_cnt_q   <= '0;
      is_write_q   <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      aw_valid_q   <= 1'b0;
      w_valid_q    <= 1'b0;
      b_ready_q    <= 1'b0;
      ar_valid_q   <= 1'b0;
      r_ready_q    <= 1'b0;
      fetch_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      tx_q         <= 1'b1;
      tx_shift_q   <= '1;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      reply_q      <= '0;
      reply_left_q <= '0;
`ifdef UART_AXI_LOADER_TIMEOUT_EN
      to_cnt_q     <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (rx_valid_q) begin
            busy_q     <= 1'b1;
            byte_cnt_q <= '0;
            if (rx_byte_q == 8'h57 || rx_byte_q == 8'h52) begin
              is_write_q <= (rx_byte_q == 8'h57);
              state_q    <= S_ADDR;
            end
            if (rx_byte_q == 8'h47) fetch_en_q <= 1'b1;
          end
        end
        S_ADDR: begin
          if (rx_valid_q) begin
            addr_q     <= {rx_byte_q, addr_q[AXI_ADDR_WIDTH-1:8]};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              if (is_write_q) begin
                state_q <= S_DATA;
              end else begin
                state_q    <= S_AXI_REQ;
                ar_valid_q <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (rx_valid_q) begin
            data_q     <= {rx_byte_q, data_q[AXI_DATA_WIDTH-1:8]};
            byte_cnt_q <= byte_cnt_q + 1'b1;
            if (byte_cnt_q == 2'd3) begin
              state_q    <= S_AXI_REQ;
              aw_valid_q <= 1'b1;
              w_valid_q  <= 1'b1;
            end
          end
        end
        S_AXI_REQ: begin
          if (is_write_q) begin
            // AW and W retire independently; B is opened once both are gone.
            if (aw_valid_q && axi.aw_ready) aw_valid_q <= 1'b0;
            if (w_valid_q && axi.w_ready)   w_valid_q  <= 1'b0;
            if ((!aw_valid_q || axi.aw_ready) && (!w_valid_q || axi.w_ready)) begin
              b_ready_q <= 1'b1;
              state_q   <= S_AXI_RESP;
            end
          end else if (axi.ar_ready) begin
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b1;
            state_q    <= S_AXI_RESP;
          end
        end
        S_AXI_RESP: begin
          if (is_write_q && axi.b_valid)  b_ready_q <= 1'b0;
          if (!is_write_q && axi.r_valid) r_ready_q <= 1'b0;
        end
        S_REPLY: begin
          // Bit index 0 = start, 1..8 = data, 9 = stop.
          if (tx_cnt_q == BIT_END) begin
            tx_cnt_q <= '0;
            if (tx_bit_q == 4'd9) begin
              if (reply_left_q != 3'd0) begin
                tx_q         <= 1'b0;
                tx_shift_q   <= {1'b1, reply_q[7:0]};
                tx_bit_q     <= '0;
                reply_q      <= {8'h00, reply_q[31:8]};
                reply_left_q <= reply_left_q - 1'b1;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b1, tx_shift_q[8:1]};
              tx_bit_q   <= tx_bit_q + 1'b1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase

`ifdef UART_AXI_LOADER_TIMEOUT_EN
      if (state_q == S_ADDR || state_q == S_DATA) begin
        if (rx_valid_q) begin
          to_cnt_q <= '0;
        end else if (to_cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
          to_cnt_q <= '0;
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
        end else begin
          to_cnt_q <= to_cnt_q + 1'b1;
        end
      end else begin
        to_cnt_q <= '0;
      end
`endif

      if (reply_en_d) begin
        state_q      <= S_REPLY;
        tx_q         <= 1'b0;
        tx_shift_q   <= {1'b1, reply_data_d[7:0]};
        tx_bit_q     <= '0;
        tx_cnt_q     <= '0;
        reply_q      <= reply_data_d[39:8];
        reply_left_q <= reply_len_d - 3'd1;
      end
    end
  end

  assign tx_o           = tx_q;
  assign fetch_enable_o = fetch_en_q;
  assign busy_o         = busy_q;

  assign axi.aw_id     = {AXI_ID_WIDTH{1'b0}};
  assign axi.aw_addr   = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign axi.aw_len    = 8'd0;
  assign axi.aw_size   = 3'b010;
  assign axi.aw_burst  = 2'b01;
  assign axi.aw_lock   = 1'b0;
  assign axi.aw_cache  = 4'd0;
  assign axi.aw_prot   = 3'd0;
  assign axi.aw_region = 4'd0;
  assign axi.aw_qos    = 4'd0;
  assign axi.aw_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi.aw_valid  = aw_valid_q;
  assign axi.w_data    = data_q;
  assign axi.w_strb    = '1;
  assign axi.w_last    = 1'b1;
  assign axi.w_user    = {AXI_USER_WIDTH{1'b0}};
  assign axi.w_valid   = w_valid_q;
  assign axi.b_ready   = b_ready_q;
  assign axi.ar_id     = {AXI_ID_WIDTH{1'b0}};
  assign axi.ar_addr   = {addr_q[AXI_ADDR_WIDTH-1:2], 2'b00};
  assign axi.ar_len    = 8'd0;
  assign axi.ar_size   = 3'b010;
  assign axi.ar_burst  = 2'b01;
  assign axi.ar_lock   = 1'b0;
  assign axi.ar_cache  = 4'd0;
  assign axi.ar_prot   = 3'd0;
  assign axi.ar_region = 4'd0;
  assign axi.ar_qos    = 4'd0;
  assign axi.ar_user   = {AXI_USER_WIDTH{1'b0}};
  assign axi.ar_valid  = ar_valid_q;
  assign axi.r_ready   = r_ready_q;
endmodule

// File: tb/tb_uart_axi_loader.sv
// Directed bench for uart_axi_loader: UART host driver, TX byte collector,
// AXI slave model with configurable AW delay and response codes.
module tb_uart_axi_loader;
  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 62_500;
  localparam int DIV      = 16;
  localparam int TIMEOUT  = 2000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic tx, fetch, busy;

  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2), .AXI_USER_WIDTH(2)) axi_if ();

  uart_axi_loader #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(2), .AXI_USER_WIDTH(2),
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_i(rst), .rx_i(rx), .tx_o(tx), .axi(axi_if),
    .fetch_enable_o(fetch), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int          aw_delay = 0;
  int          aw_wait  = 0;
  logic [1:0]  b_resp_cfg = 2'b00;
  logic [1:0]  r_resp_cfg = 2'b00;
  logic [31:0] r_data_cfg = 32'h0;

  initial begin
    axi_if.aw_ready = 0; axi_if.w_ready = 0; axi_if.ar_ready = 0;
    axi_if.b_valid = 0; axi_if.b_resp = 0; axi_if.b_id = 0; axi_if.b_user = 0;
    axi_if.r_valid = 0; axi_if.r_resp = 0; axi_if.r_data = 0; axi_if.r_id = 0;
    axi_if.r_last = 1; axi_if.r_user = 0;
    forever begin
      @(negedge clk);
      if (axi_if.aw_valid && !axi_if.aw_ready) begin
        if (aw_wait >= aw_delay) axi_if.aw_ready = 1;
        else aw_wait++;
      end else begin
        axi_if.aw_ready = 0;
        aw_wait = 0;
      end
      axi_if.w_ready  = axi_if.w_valid && !axi_if.w_ready;
      axi_if.ar_ready = axi_if.ar_valid && !axi_if.ar_ready;
      if (axi_if.b_valid && !axi_if.b_ready) axi_if.b_valid = 0;
      else if (!axi_if.b_valid && axi_if.b_ready) begin
        axi_if.b_valid = 1;
        axi_if.b_resp  = b_resp_cfg;
      end
      if (axi_if.r_valid && !axi_if.r_ready) axi_if.r_valid = 0;
      else if (!axi_if.r_valid && axi_if.r_ready) begin
        axi_if.r_valid = 1;
        axi_if.r_resp  = r_resp_cfg;
        axi_if.r_data  = r_data_cfg;
      end
    end
  end

  // ---------------- AXI monitor ----------------
  int cyc = 0;
  int aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  int aw_hs_cyc = 0, w_hs_cyc = 0, bready_rise_cyc = 0, awv_rise_cyc = 0, wv_rise_cyc = 0;
  logic [31:0] aw_addr_seen, w_data_seen, ar_addr_seen;
  logic [3:0]  w_strb_seen;
  logic        w_last_seen;
  logic [7:0]  aw_len_seen;
  logic [2:0]  aw_size_seen;
  logic [1:0]  aw_burst_seen;
  logic        awv_prev = 0, wv_prev = 0, br_prev = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (axi_if.aw_valid && axi_if.aw_ready) begin
      aw_cnt++; aw_hs_cyc = cyc; aw_addr_seen = axi_if.aw_addr;
      aw_len_seen = axi_if.aw_len; aw_size_seen = axi_if.aw_size; aw_burst_seen = axi_if.aw_burst;
    end
    if (axi_if.w_valid && axi_if.w_ready) begin
      w_cnt++; w_hs_cyc = cyc; w_data_seen = axi_if.w_data;
      w_strb_seen = axi_if.w_strb; w_last_seen = axi_if.w_last;
    end
    if (axi_if.ar_valid && axi_if.ar_ready) begin
      ar_cnt++; ar_addr_seen = axi_if.ar_addr;
    end
    if (axi_if.aw_valid && !awv_prev) awv_rise_cyc = cyc;
    if (axi_if.w_valid && !wv_prev) wv_rise_cyc = cyc;
    if (axi_if.b_ready && !br_prev) bready_rise_cyc = cyc;
    awv_prev = axi_if.aw_valid; wv_prev = axi_if.w_valid; br_prev = axi_if.b_ready;
  end

  // ---------------- UART TX collector ----------------
  logic [7:0] rx_bytes[$];
  logic [7:0] col_byte;

  initial begin
    wait (rst == 1'b0);
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        col_byte[i] = tx;
      end
      repeat (DIV) @(posedge clk);
      rx_bytes.push_back(col_byte);
    end
  end

  // ---------------- host-side helpers ----------------
  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    @(posedge clk);
    rx = 1'b0;
    repeat (DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(posedge clk);
    end
    rx = stop_bit;
    repeat (DIV) @(posedge clk);
    rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic wait_reply(input int n);
    int budget;
    budget = n * 12 * DIV + 200;
    while (rx_bytes.size() < n && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    check("reply_count", rx_bytes.size(), n);
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] exp);
    logic [7:0] v;
    v = 8'hxx;
    if (rx_bytes.size() > 0) v = rx_bytes.pop_front();
    check(tag, v, exp);
  endtask

  task automatic settle_idle();
    repeat (DIV + 4) @(posedge clk);
    @(negedge clk);
    check("busy_after_reply", busy, 1'b0);
  endtask

  int ar_before, aw_before;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_fetch", fetch, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_awvalid", axi_if.aw_valid, 1'b0);
    check("rst_wvalid", axi_if.w_valid, 1'b0);
    check("rst_arvalid", axi_if.ar_valid, 1'b0);
    check("rst_bready", axi_if.b_ready, 1'b0);
    check("rst_rready", axi_if.r_ready, 1'b0);
    @(posedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);

    // W 0x100 <= 0xDEADBEEF, OKAY
    send_byte(8'h57);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
    wait_reply(1);
    expect_byte("w_reply", 8'h06);
    check("w_aw_cnt", aw_cnt, 1);
    check("w_w_cnt", w_cnt, 1);
    check("w_aw_addr", aw_addr_seen, 32'h0000_0100);
    check("w_data", w_data_seen, 32'hDEAD_BEEF);
    check("w_strb", w_strb_seen, 4'hF);
    check("w_last", w_last_seen, 1'b1);
    check("w_aw_len", aw_len_seen, 8'd0);
    check("w_aw_size", aw_size_seen, 3'b010);
    check("w_aw_burst", aw_burst_seen, 2'b01);
    check("w_valids_same_cycle", awv_rise_cyc, wv_rise_cyc);
    settle_idle();

    // R 0x100 -> 0xDEADBEEF, OKAY
    r_data_cfg = 32'hDEAD_BEEF;
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_reply(5);
    expect_byte("r_ack", 8'h06);
    expect_byte("r_b0", 8'hEF);
    expect_byte("r_b1", 8'hBE);
    expect_byte("r_b2", 8'hAD);
    expect_byte("r_b3", 8'hDE);
    check("r_ar_cnt", ar_cnt, 1);
    check("r_ar_addr", ar_addr_seen, 32'h0000_0100);
    settle_idle();

    // W with delayed AW, SLVERR, unaligned address
    aw_delay = 5;
    b_resp_cfg = 2'b10;
    send_byte(8'h57);
    send_byte(8'h07); send_byte(8'h00); send_byte(8'h00); send_byte(8'h20);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_reply(1);
    expect_byte("slverr_reply", 8'h15);
    check("slverr_aw_addr_aligned", aw_addr_seen, 32'h2000_0004);
    check("slverr_w_data", w_data_seen, 32'h4433_2211);
    check("slverr_w_before_aw", (w_hs_cyc < aw_hs_cyc), 1'b1);
    check("slverr_bready_after_aw", (bready_rise_cyc > aw_hs_cyc), 1'b1);
    check("slverr_aw_cnt", aw_cnt, 2);
    settle_idle();
    aw_delay = 0;
    b_resp_cfg = 2'b00;

    // G then unknown opcode
    aw_before = aw_cnt;
    ar_before = ar_cnt;
    check("g_fetch_before", fetch, 1'b0);
    send_byte(8'h47);
    @(negedge clk);
    check("g_busy_during_reply", busy, 1'b1);
    check("g_fetch_after", fetch, 1'b1);
    wait_reply(1);
    expect_byte("g_reply", 8'h06);
    settle_idle();
    send_byte(8'hAA);
    wait_reply(1);
    expect_byte("unknown_reply", 8'h3F);
    check("unknown_no_aw", aw_cnt, aw_before);
    check("unknown_no_ar", ar_cnt, ar_before);
    check("fetch_sticky", fetch, 1'b1);
    settle_idle();

    // Frame error on the byte after the opcode
    r_data_cfg = 32'h1234_5678;
    send_byte(8'h52);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    wait_reply(5);
    expect_byte("ferr_ack", 8'h06);
    expect_byte("ferr_b0", 8'h78);
    expect_byte("ferr_b1", 8'h56);
    expect_byte("ferr_b2", 8'h34);
    expect_byte("ferr_b3", 8'h12);
    check("ferr_ar_addr", ar_addr_seen, 32'h0000_0100);
    check("ferr_ar_cnt", ar_cnt, ar_before + 1);
    settle_idle();

    // Partial frame followed by a long idle
    ar_before = ar_cnt;
    r_data_cfg = 32'hCAFE_F00D;
    send_byte(8'h52);
    send_byte(8'h00);
    repeat (TIMEOUT + 10) @(posedge clk);
    @(negedge clk);
`ifdef UART_AXI_LOADER_TIMEOUT_EN
    check("timeout_busy_low", busy, 1'b0);
    check("timeout_no_ar", ar_cnt, ar_before);
    check("timeout_no_reply", rx_bytes.size(), 0);
    send_byte(8'h52);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`else
    check("no_timeout_busy_high", busy, 1'b1);
    check("no_timeout_no_ar", ar_cnt, ar_before);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
`endif
    wait_reply(5);
    expect_byte("late_r_ack", 8'h06);
    expect_byte("late_r_b0", 8'h0D);
    expect_byte("late_r_b1", 8'hF0);
    expect_byte("late_r_b2", 8'hFE);
    expect_byte("late_r_b3", 8'hCA);
    check("late_r_ar_cnt", ar_cnt, ar_before + 1);
    check("late_r_ar_addr", ar_addr_seen, 32'h0000_0000);
    settle_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end
endmodule
